// File: rtl/mac_chain_driver_if.sv
// Bundle of the FIFO, MAC-chain and result signals between the chain sequencer
// and its surroundings; master is the sequencer side.
interface mac_chain_driver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MAC    = 8
);
    localparam int RES_W = 3 * DATA_WIDTH;
    localparam int IDX_W = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;

    logic                          start;
    logic                          busy;
    logic                          done;
    logic [NUM_MAC-1:0]            a_empty;
    logic [NUM_MAC*DATA_WIDTH-1:0] a_dout;
    logic [NUM_MAC-1:0]            a_rd_en;
    logic                          b_empty;
    logic [DATA_WIDTH-1:0]         b_dout;
    logic                          b_rd_en;
    logic                          mac_clr;
    logic                          mac_en;
    logic [DATA_WIDTH-1:0]         mac_bin;
    logic [NUM_MAC*DATA_WIDTH-1:0] mac_ain;
    logic [NUM_MAC*RES_W-1:0]      mac_cout;
    logic                          result_valid;
    logic                          result_ready;
    logic [RES_W-1:0]              result_data;
    logic [IDX_W-1:0]              result_idx;
    logic                          underflow;

    modport master (
        input  start, a_empty, a_dout, b_empty, b_dout, mac_cout, result_ready,
        output busy, done, a_rd_en, b_rd_en, mac_clr, mac_en, mac_bin, mac_ain,
               result_valid, result_data, result_idx, underflow
    );

    modport slave (
        output start, a_empty, a_dout, b_empty, b_dout, mac_cout, result_ready,
        input  busy, done, a_rd_en, b_rd_en, mac_clr, mac_en, mac_bin, mac_ain,
               result_valid, result_data, result_idx, underflow
    );
endinterface

// File: rtl/mac_chain_driver.sv
// Sequences one matrix-vector product through the systolic MAC chain: clear,
// stream skewed operands, wait for the last stage, then drain results.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; underflow cleared when start is taken
// S_CLEAR  | one-cycle broadcast clear of every accumulator
// S_STREAM | VEC_LEN cycles of En/Bin into stage 0, B popped each cycle
// S_DRAIN  | NUM_MAC cycles while the enable skew reaches the last stage
// S_OUTPUT | NUM_MAC results handed out on the valid/ready port
module mac_chain_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MAC    = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mac_chain_driver_if.master bus
);
    localparam int RES_W   = 3 * DATA_WIDTH;
    localparam int IDX_W   = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;
    localparam int CNT_MAX = (VEC_LEN > NUM_MAC) ? VEC_LEN : NUM_MAC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] STREAM_LOAD = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(NUM_MAC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_MAC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rd_sel;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               uf_q, uf_d;
    logic [RES_W-1:0]   data_q, data_d;
    logic [NUM_MAC-2:0] en_pipe_q;
    logic [NUM_MAC-1:0] en_pipe;
    logic               mac_en;
    logic               pop_err;
    logic [RES_W-1:0]   cout_arr [NUM_MAC];

    assign mac_en  = (state_q == S_STREAM);
    // Stage i's enable trails stage 0 by i cycles, matching the chain's En_out delay.
    assign en_pipe = {en_pipe_q, mac_en};

    for (genvar g = 0; g < NUM_MAC; g++) begin : g_row
        assign cout_arr[g] = bus.mac_cout[g*RES_W +: RES_W];
        assign bus.mac_ain[g*DATA_WIDTH +: DATA_WIDTH] =
            en_pipe[g] ? bus.a_dout[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign pop_err = (mac_en & bus.b_empty) | (|(en_pipe & bus.a_empty));

    // Row whose Cout gets loaded next: row 0 on OUTPUT entry, else the following row.
    assign rd_sel = (state_q == S_OUTPUT) ? idx_q + IDX_W'(1) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        uf_d    = uf_q | pop_err;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    uf_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                cnt_d   = STREAM_LOAD;
            end
            S_STREAM: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_OUTPUT;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = cout_arr[rd_sel];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (valid_q && bus.result_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = rd_sel;
                        data_d = cout_arr[rd_sel];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            uf_q      <= 1'b0;
            en_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            done_q    <= done_d;
            uf_q      <= uf_d;
            en_pipe_q <= en_pipe[NUM_MAC-2:0];
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.a_rd_en      = en_pipe;
    assign bus.b_rd_en      = mac_en;
    assign bus.mac_clr      = (state_q == S_CLEAR);
    assign bus.mac_en       = mac_en;
    assign bus.mac_bin      = mac_en ? bus.b_dout : '0;
    assign bus.result_valid = valid_q;
    assign bus.result_data  = data_q;
    assign bus.result_idx   = idx_q;
    assign bus.underflow    = uf_q;
endmodule

// File: doc/mac_chain_driver.md
# mac_chain_driver

Sequencer that drives the systolic MAC chain for one matrix-vector product and drains the results. It pops B elements and per-row A elements from first-word-fall-through FIFOs and issues a one-cycle clear. It drives En and Bin into MAC 0 and the per-stage Ain values, skewed to match the chain's one-cycle-per-stage En/Bin delay. Once the last stage settles, it streams the NUM_MAC accumulated results out on a valid/ready port.

## Interface
- DATA_WIDTH, 8, operand width; each result is 3*DATA_WIDTH bits.
- NUM_MAC, 8, number of MAC stages (matrix rows).
- VEC_LEN, 8, elements per vector (matrix columns).
- clk  in  1  clock. Reset is rst_n, asynchronous, active-low; clock is clk.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a job when sampled high in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- a_empty  in  NUM_MAC  per-row FIFO empty flags.
- a_dout  in  NUM_MAC*DATA_WIDTH  per-row FWFT head data; row i is [i*DATA_WIDTH +: DATA_WIDTH].
- a_rd_en  out  NUM_MAC  per-row pop.
- b_empty  in  1  B FIFO empty flag.
- b_dout  in  DATA_WIDTH  B FWFT head data.
- b_rd_en  out  1  B pop.
- mac_clr  out  1  broadcast Clr to all stages.
- mac_en  out  1  En into stage 0.
- mac_bin  out  DATA_WIDTH  Bin into stage 0.
- mac_ain  out  NUM_MAC*DATA_WIDTH  Ain per stage, packed like a_dout.
- mac_cout  in  NUM_MAC*3*DATA_WIDTH  Cout of each stage, packed by stage index.
- result_valid  out  1  result_data is valid.
- result_ready  in  1  consumer accepts the result.
- result_data  out  3*DATA_WIDTH  accumulated dot product.
- result_idx  out  $clog2(NUM_MAC)  row index of result_data.
- underflow  out  1  sticky: a pop was issued while the corresponding FIFO was empty.

## Operation
- FSM states and transitions:
  - IDLE: start -> CLEAR.
  - CLEAR: 1 cycle -> STREAM.
  - STREAM: VEC_LEN cycles -> DRAIN.
  - DRAIN: NUM_MAC cycles -> OUTPUT.
  - OUTPUT: after NUM_MAC handshakes -> IDLE, with done pulsed.
- CLEAR: mac_clr=1. The underflow flag is cleared on start acceptance.
- STREAM: mac_en=1, b_rd_en=1, mac_bin=b_dout.
- en_pipe[0]=mac_en; en_pipe[i] is en_pipe[i-1] registered. This matches each stage's En_out delay.
- Per-row A feed: a_rd_en[i]=en_pipe[i]; mac_ain[i]=en_pipe[i] ? a_dout[i] : 0.
  - en_pipe continues shifting through DRAIN.
- No stalling: once STREAM starts, the schedule is fixed. Producers must have VEC_LEN entries in every FIFO before start.
- underflow is set by either of these:
  - b_rd_en && b_empty;
  - any a_rd_en[i] && a_empty[i].
  - It holds until the next accepted start. The job completes regardless, with undefined result values.
- OUTPUT: result_idx counts 0..NUM_MAC-1.
  - result_data is registered: loaded with mac_cout[idx] on OUTPUT entry and after each handshake.
  - result_valid stays high until result_valid && result_ready.
- start while busy is ignored.

## Timing
- Cycle 0: start accepted in IDLE. Cycle 1: CLEAR. Cycles 2..VEC_LEN+1: STREAM.
- Stage i sees its k-th element at cycle 2+k+i. Its final Cout is visible at cycle VEC_LEN+2+i.
- DRAIN covers cycles VEC_LEN+2..VEC_LEN+NUM_MAC+1.
- First result_valid appears at cycle VEC_LEN+NUM_MAC+2 (18 with defaults).
- With result_ready held high, one result per cycle. done pulses the cycle after the last handshake, and busy drops in that same cycle.
- Reset values are 0 for every output: busy, done, a_rd_en, b_rd_en, mac_clr, mac_en, mac_bin, mac_ain, result_valid, result_data, result_idx, underflow. FSM resets to IDLE, en_pipe resets to all zero.
- Reset asserted mid-job aborts immediately; no pops are issued after reset.
- A start in the same cycle that done pulses is accepted, since the FSM is already in IDLE.

## Test plan
- Row i = {i+1 repeated 8}, B = {1..8}, ready high:
  - results idx 0..7 = 36*(i+1);
  - first valid at cycle 18;
  - done at cycle 26.
- All A and B = 255: every result = 520200 (no 24-bit overflow). a_rd_en[7] is high exactly on cycles 9..16.
- result_ready toggled 1/0 per cycle: each result held stable while not ready. Indices stay in order; no result is duplicated or dropped.
- Two back-to-back jobs, with the second start coinciding with done: the second job's results are correct and unaffected by the first (clr observed at cycle 1 of job 2).
- B FIFO holding only 7 entries: underflow set in the 8th STREAM cycle; job still completes and done pulses. Next start clears underflow.
- rst_n pulsed low at cycle 5 of STREAM: all outputs immediately 0, FSM in IDLE, no further pops. A new job then yields correct results.
